// File: rtl/logico_pipe.sv
// logico_pipe: two-stage pipelined bitwise logic unit with valid/ready handshakes.
//
// Result before inversion is selected by op[1:0]: 00 zero, 01 A&B, 10 A|B, 11 A^B.
// Setting op[2] inverts that result, giving all-ones, NAND, NOR and XNOR.
//
// Pipeline:
//   S1 captures A, B and op on an input handshake.
//   S2 captures the result and its zero flag. S2 drives Out, out_valid and zero.
//   An accepted operand set reaches Out two cycles later when nothing downstream stalls.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   A, B [WIDTH]       operands, sampled only on in_valid && in_ready
//   op   [3]           opcode
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   Out  [WIDTH]       registered result
//   out_valid          Out holds a result
//   out_ready          consumer accepts Out this cycle
//   zero               Out == 0, qualified by out_valid
//   txn_count [CNT_W]  output handshakes since reset, wraps to zero
//
// Optional feature, macro LOGICO_PARITY_EN. Defining it adds two registered S2 outputs:
//   parity             XOR-reduction of Out
//   ones               population count of Out, $clog2(WIDTH+1) bits
module logico_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic [CNT_W-1:0] txn_count
`ifdef LOGICO_PARITY_EN
    ,
    output logic                         parity,
    output logic [$clog2(WIDTH+1)-1:0]   ones
`endif
);

`ifdef LOGICO_PARITY_EN
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);
`endif

    // Stage 1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    // Handshake and control
    logic             stall_c;
    logic             s2_load_c;
    logic             in_hs_c;
    logic             out_hs_c;

    logic [WIDTH-1:0] base_c;
    logic [WIDTH-1:0] res_c;

    // S2 holds while its result is offered but not taken
    assign stall_c   = out_valid && !out_ready;
    assign s2_load_c = !stall_c;
    assign in_ready  = !s1_valid || !stall_c;
    assign in_hs_c   = in_valid && in_ready;
    assign out_hs_c  = out_valid && out_ready;

    // Legacy two-bit function select, then optional inversion
    always_comb begin
        base_c = '0;
        unique case (s1_op[1:0])
            2'b00:   base_c = '0;
            2'b01:   base_c = s1_a & s1_b;
            2'b10:   base_c = s1_a | s1_b;
            2'b11:   base_c = s1_a ^ s1_b;
            default: base_c = '0;
        endcase
        res_c = base_c ^ {WIDTH{s1_op[2]}};
    end

`ifdef LOGICO_PARITY_EN
    logic [ONES_W-1:0] ones_c;

    // Population count of the result being loaded into S2
    always_comb begin
        ones_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_c = ones_c + ONES_W'(res_c[i]);
        end
    end
`endif

    // S1: capture on input handshake; empty when it drains into S2 with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_hs_c) begin
            s1_valid <= 1'b1;
            s1_a     <= A;
            s1_b     <= B;
            s1_op    <= op;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: advance whenever not stalled; an empty S1 leaves a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            zero      <= s1_valid && (res_c == '0);
            if (s1_valid) begin
                Out <= res_c;
            end
        end
    end

`ifdef LOGICO_PARITY_EN
    // Parity and popcount travel with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
            ones   <= '0;
        end else if (s2_load_c && s1_valid) begin
            parity <= ^res_c;
            ones   <= ones_c;
        end
    end
`endif

    // Delivered-transaction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (out_hs_c) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logico_pipe.sv
// Testbench for logico_pipe: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the operand stream.
module tb_logico_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Out;
    logic             out_valid;
    logic             out_ready;
    logic             zero;
    logic [CNT_W-1:0] txn_count;
`ifdef LOGICO_PARITY_EN
    logic             parity;
    logic [5:0]       ones;
`endif

    logico_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out       (Out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero),
        .txn_count (txn_count)
`ifdef LOGICO_PARITY_EN
        ,
        .parity    (parity),
        .ones      (ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int delivered = 0;
    logic [WIDTH-1:0] exp_q[$];

    logic             was_stall = 1'b0;
    logic [WIDTH-1:0] prev_out;
    logic             prev_valid;
    logic             prev_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: each opcode names one of eight bitwise functions
    function automatic logic [WIDTH-1:0] ref_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] o);
        case (o)
            3'd0: return '0;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return '1;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] o, input logic r);
        in_valid  = v;
        A         = a;
        B         = b;
        op        = o;
        out_ready = r;
    endtask

    // One clock: check outputs against the model, cross the edge, update the model
    task automatic tick();
        logic in_hs;
        logic out_hs;
        logic [WIDTH-1:0] e;
        #1;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check("out_data", Out, e);
                check("out_zero", 32'(zero), 32'(e == '0));
`ifdef LOGICO_PARITY_EN
                check("out_parity", 32'(parity), 32'($countones(e) % 2));
                check("out_ones", 32'(ones), 32'($countones(e)));
`endif
            end
        end
        if (was_stall) begin
            check("stall_hold_out", Out, prev_out);
            check("stall_hold_valid", 32'(out_valid), 32'(prev_valid));
            check("stall_hold_zero", 32'(zero), 32'(prev_zero));
        end
        prev_out   = Out;
        prev_valid = out_valid;
        prev_zero  = zero;
        was_stall  = out_valid && !out_ready;
        @(posedge clk);
        #1;
        if (in_hs) exp_q.push_back(ref_fn(A, B, op));
        if (out_hs) begin
            void'(exp_q.pop_front());
            delivered++;
        end
        check("txn_count", 32'(txn_count), 32'(delivered % CNT_MOD));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_out", Out, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
`ifdef LOGICO_PARITY_EN
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Legacy AND: result two cycles after acceptance
        drive(1'b1, 32'd30, 32'd40, 3'b001, 1'b1);
        tick();
        check("and_lat1_valid", 32'(out_valid), 32'd0);
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        tick();
        check("and_valid", 32'(out_valid), 32'd1);
        check("and_out", Out, 32'h0000_0008);
        check("and_zero", 32'(zero), 32'd0);
        tick();
        check("and_txn", 32'(txn_count), 32'd1);

        // Back-to-back stream
        drive(1'b1, 32'd30, 32'd40, 3'b010, 1'b1);
        tick();
        drive(1'b1, 32'd30, 32'd40, 3'b011, 1'b1);
        tick();
        check("stream_0", Out, 32'h0000_003E);
        drive(1'b1, 32'd30, 32'd40, 3'b101, 1'b1);
        tick();
        check("stream_1", Out, 32'h0000_0036);
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        tick();
        check("stream_2", Out, 32'hFFFF_FFF7);
        check("stream_2_valid", 32'(out_valid), 32'd1);
        tick();
        check("stream_done_valid", 32'(out_valid), 32'd0);
        check("stream_txn", 32'(txn_count), 32'd4);

        // Backpressure: S2 and S1 fill, then input blocks
        drive(1'b1, 32'd30, 32'd40, 3'b001, 1'b0);
        tick();
        drive(1'b1, 32'd30, 32'd40, 3'b010, 1'b0);
        tick();
        drive(1'b1, 32'd30, 32'd40, 3'b011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_hold", Out, 32'h0000_0008);
            tick();
        end
        drive(1'b1, 32'd30, 32'd40, 3'b011, 1'b1);
        tick();
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_txn", 32'(txn_count), 32'(7 % CNT_MOD));

        // Zero flag cases
        drive(1'b1, 32'h0F, 32'hF0, 3'b001, 1'b1);
        tick();
        drive(1'b1, 32'h0F, 32'hF0, 3'b000, 1'b1);
        tick();
        check("zf_and_out", Out, 32'd0);
        check("zf_and_zero", 32'(zero), 32'd1);
        drive(1'b1, 32'h0F, 32'hF0, 3'b100, 1'b1);
        tick();
        check("zf_zero_out", Out, 32'd0);
        check("zf_zero_zero", 32'(zero), 32'd1);
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        tick();
        check("zf_ones_out", Out, 32'hFFFF_FFFF);
        check("zf_ones_zero", 32'(zero), 32'd0);
        tick();

        // Reset mid-flight discards everything at once
        drive(1'b1, 32'd30, 32'd40, 3'b011, 1'b0);
        tick();
        drive(1'b1, 32'd30, 32'd40, 3'b001, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", Out, 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        delivered = 0;
        was_stall = 1'b0;
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            tick();
        end
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_idle_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
